// File: rtl/line_window_buffer.sv
// Row-window generator: presents ROWS vertically aligned pixels per shift, with top-border gating and bottom flush.
// Optional LINE_WINDOW_REPLICATE_BORDER_EN: flush pads replicate the line above instead of zero.
module line_window_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int LINE_WIDTH  = 10,
  parameter int ROWS        = 9,
  parameter int FLUSH_LINES = (ROWS - 1) / 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_i,
  input  logic [DATA_WIDTH-1:0]           data_i,
  input  logic                            done_i,
  output logic                            ready_o,
  output logic [ROWS*DATA_WIDTH-1:0]      rows_o,
  output logic                            valid_o,
  output logic [$clog2(LINE_WIDTH)-1:0]   col_o,
  output logic                            done_o
);

  localparam int COL_W  = $clog2(LINE_WIDTH);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int FL_MAX = FLUSH_LINES * LINE_WIDTH + LINE_WIDTH;
  localparam int FL_W   = $clog2(FL_MAX + 1);
  localparam int NBUF   = ROWS - 1;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [FL_W-1:0]  FL_LINES  = FL_W'(FLUSH_LINES * LINE_WIDTH);
  localparam logic [FL_W-1:0]  FL_LWIDTH = FL_W'(LINE_WIDTH);

  // IDLE: wait for frame | RUN: accept pixels | FLUSH: shift pads | DONE: pulse done_o, clear counters
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [COL_W-1:0]        col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0]        row_cnt_q, row_cnt_d;
  logic [FL_W-1:0]         flush_cnt_q, flush_cnt_d;
  logic [FL_W-1:0]         flush_load;
  logic [ROWS*DATA_WIDTH-1:0] rows_q;
  logic [COL_W-1:0]        col_q;
  logic                    valid_q;
  logic                    done_q;

  logic                    accept;
  logic                    shift;
  logic [DATA_WIDTH-1:0]   pix;
  logic [DATA_WIDTH-1:0]   pad;
  logic [DATA_WIDTH-1:0]   lane_raw [ROWS];
  logic [ROWS*DATA_WIDTH-1:0] lanes_gated;

  logic [DATA_WIDTH-1:0]   mem_q [NBUF][LINE_WIDTH];

  assign ready_o = !rst && ((state_q == S_IDLE) || (state_q == S_RUN));
  assign accept  = valid_i && ready_o;

`ifdef LINE_WINDOW_REPLICATE_BORDER_EN
  assign pad = (row_cnt_q == '0) ? '0 : mem_q[0][col_cnt_q];
`else
  assign pad = '0;
`endif

  always_comb begin
    lane_raw[0] = pix;
    for (int k = 1; k < ROWS; k++) begin
      lane_raw[k] = mem_q[k-1][col_cnt_q];
    end
    lanes_gated = '0;
    for (int k = 0; k < ROWS; k++) begin
      if (k <= int'(row_cnt_q)) begin
        lanes_gated[k*DATA_WIDTH +: DATA_WIDTH] = lane_raw[k];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    flush_cnt_d = flush_cnt_q;
    shift       = 1'b0;
    pix         = data_i;
    flush_load  = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift   = 1'b1;
          state_d = done_i ? S_FLUSH : S_RUN;
        end else if (done_i) begin
          state_d = S_DONE;
        end
      end
      S_RUN: begin
        shift = accept;
        if (done_i) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        shift       = 1'b1;
        pix         = pad;
        flush_cnt_d = flush_cnt_q - FL_W'(1);
        if (flush_cnt_q <= FL_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        col_cnt_d = '0;
        row_cnt_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (shift) begin
      if (col_cnt_q == COL_LAST) begin
        col_cnt_d = '0;
        if (row_cnt_q != ROW_LAST) begin
          row_cnt_d = row_cnt_q + ROW_W'(1);
        end
      end else begin
        col_cnt_d = col_cnt_q + COL_W'(1);
      end
    end

    // Pad count is taken from the column after this cycle's shift: remainder of the line plus whole flush lines.
    if ((state_d == S_FLUSH) && (state_q != S_FLUSH)) begin
      flush_load = FL_LINES + ((col_cnt_d == '0) ? FL_W'(0) : (FL_LWIDTH - FL_W'(col_cnt_d)));
      flush_cnt_d = flush_load;
      if (flush_load == '0) begin
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      flush_cnt_q <= '0;
      rows_q      <= '0;
      col_q       <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      valid_q     <= shift;
      done_q      <= (state_d == S_DONE);
      if (shift) begin
        rows_q <= lanes_gated;
        col_q  <= col_cnt_q;
      end
    end
  end

  // Line storage is not reset; the top-border gating masks stale contents.
  always_ff @(posedge clk) begin
    if (!rst && shift) begin
      for (int j = 0; j < NBUF; j++) begin
        mem_q[j][col_cnt_q] <= lane_raw[j];
      end
    end
  end

  assign rows_o  = rows_q;
  assign valid_o = valid_q;
  assign col_o   = col_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Scoreboard bench for line_window_buffer (DATA_WIDTH=8, LINE_WIDTH=4, ROWS=3).
module tb_line_window_buffer;

`ifdef LINE_WINDOW_REPLICATE_BORDER_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [7:0]  data_i;
  logic        done_i;
  logic        ready_o;
  logic [23:0] rows_o;
  logic        valid_o;
  logic [1:0]  col_o;
  logic        done_o;

  line_window_buffer #(
    .DATA_WIDTH(8),
    .LINE_WIDTH(4),
    .ROWS(3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .valid_i(valid_i),
    .data_i (data_i),
    .done_i (done_i),
    .ready_o(ready_o),
    .rows_o (rows_o),
    .valid_o(valid_o),
    .col_o  (col_o),
    .done_o (done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        vld;
    logic [23:0] rows;
    logic [1:0]  col;
    logic        dn;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   bad    = 0;
  int   vcount = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input int l2, input int l1, input int l0, input int c,
                              input bit dn, input bit vld);
    exp_t e;
    e.vld  = vld;
    e.rows = {8'(l2), 8'(l1), 8'(l0)};
    e.col  = 2'(c);
    e.dn   = dn;
    return e;
  endfunction

  // Expected window for pixel i of a frame numbered 1..n (4 pixels per line)
  function automatic exp_t pix_exp(input int i);
    return mk((i > 8) ? i - 8 : 0, (i > 4) ? i - 4 : 0, i, (i - 1) % 4, 1'b0, 1'b1);
  endfunction

  // Flush after a 12-pixel frame: lane1 walks 9..12, lane2 walks 5..8
  task automatic push_flush12();
    for (int c = 0; c < 4; c++)
      sb.push_back(mk(5 + c, 9 + c, REP ? 9 + c : 0, c, c == 3, 1'b1));
  endtask

  always @(negedge clk) begin
    if (valid_o === 1'b1) vcount++;
    if (valid_o === 1'b1 || done_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {62'd0, valid_o, done_o}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("valid_o", 64'(valid_o), 64'(e.vld));
        chk("done_o", 64'(done_o), 64'(e.dn));
        if (e.vld) begin
          chk("rows_o", 64'(rows_o), 64'(e.rows));
          chk("col_o", 64'(col_o), 64'(e.col));
        end
      end
    end
  end

  task automatic send(input int v, input bit dn);
    valid_i = 1'b1;
    data_i  = 8'(v);
    done_i  = dn;
    @(posedge clk); #1;
    valid_i = 1'b0;
    done_i  = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk(nm, 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int nrdy;
    int ndone;
    rst     = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    done_i  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rows", 64'(rows_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_col", 64'(col_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(ready_o), 64'd1);
    @(posedge clk); #1;

    // Continuous 12-pixel frame, done with the last pixel
    for (int i = 1; i <= 12; i++) begin
      sb.push_back(pix_exp(i));
      send(i, i == 12);
    end
    push_flush12();
    wait_drain("t1_drain");
    chk("rows_hold", 64'(rows_o), 64'({8'd8, 8'd12, REP ? 8'd12 : 8'd0}));

    // Same frame with valid_i toggling
    v0 = vcount;
    for (int i = 1; i <= 12; i++) begin
      sb.push_back(pix_exp(i));
      send(i, i == 12);
      if (i != 12) begin
        @(posedge clk); #1;
      end
    end
    push_flush12();
    wait_drain("t2_drain");
    chk("t2_valid_count", 64'(vcount - v0), 64'd16);

    // Partial-line done after pixel 6: two remainder pads then one flush line
    for (int i = 1; i <= 6; i++) begin
      sb.push_back(pix_exp(i));
    end
    sb.push_back(mk(0, 3, REP ? 3 : 0, 2, 1'b0, 1'b1));
    sb.push_back(mk(0, 4, REP ? 4 : 0, 3, 1'b0, 1'b1));
    sb.push_back(mk(1, 5, REP ? 5 : 0, 0, 1'b0, 1'b1));
    sb.push_back(mk(2, 6, REP ? 6 : 0, 1, 1'b0, 1'b1));
    sb.push_back(mk(3, REP ? 3 : 0, REP ? 3 : 0, 2, 1'b0, 1'b1));
    sb.push_back(mk(4, REP ? 4 : 0, REP ? 4 : 0, 3, 1'b1, 1'b1));
    for (int i = 1; i <= 6; i++) send(i, i == 6);
    nrdy = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (done_o === 1'b1) break;
      if (ready_o === 1'b0) nrdy++;
    end
    chk("t3_ready_low", 64'(nrdy), 64'd6);
    @(posedge clk); #1;
    wait_drain("t3_drain");

    // Reset in the middle of a flush
    for (int i = 1; i <= 12; i++) begin
      sb.push_back(pix_exp(i));
    end
    sb.push_back(mk(5, 9, REP ? 9 : 0, 0, 1'b0, 1'b1));
    sb.push_back(mk(6, 10, REP ? 10 : 0, 1, 1'b0, 1'b1));
    for (int i = 1; i <= 12; i++) send(i, i == 12);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t4_rst_valid", 64'(valid_o), 64'd0);
    chk("t4_rst_ready", 64'(ready_o), 64'd0);
    chk("t4_rst_done", 64'(done_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_o === 1'b1) ndone++;
    end
    chk("t4_no_done", 64'(ndone), 64'd0);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(pix_exp(i));
    end
    for (int c = 0; c < 4; c++)
      sb.push_back(mk(0, 1 + c, REP ? 1 + c : 0, c, c == 3, 1'b1));
    for (int i = 1; i <= 4; i++) send(i, i == 4);
    wait_drain("t4_drain");

    // Empty frame: done_i in IDLE
    v0 = vcount;
    sb.push_back(mk(0, 0, 0, 0, 1'b1, 1'b0));
    done_i = 1'b1;
    @(posedge clk); #1;
    done_i = 1'b0;
    @(negedge clk);
    chk("t5_done", 64'(done_o), 64'd1);
    chk("t5_valid", 64'(valid_o), 64'd0);
    @(negedge clk);
    chk("t5_done_pulse", 64'(done_o), 64'd0);
    @(posedge clk); #1;
    wait_drain("t5_drain");
    chk("t5_no_valid", 64'(vcount - v0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
